// File: rtl/servo_pwm_gen.sv
// Four-channel servo pulse generator: fixed frame, per-channel clamped widths,
// commands latched only at frame boundaries so pulses are never cut or stretched.
module servo_pwm_gen #(
   parameter int PRESCALE     = 48,
   parameter int PERIOD_TICKS = 20000,
   parameter int MIN_TICKS    = 500,
   parameter int MAX_TICKS    = 2500
) (
   input  logic        SYS_CLK,
   input  logic        SYS_RST_N,
   input  logic [63:0] SERVO_CMD,
   input  logic [3:0]  SERVO_EN,
   output logic [3:0]  SERVO_OUT,
   output logic        PERIOD_STROBE,
   output logic [63:0] SERVO_STATUS
);

   localparam int               PRE_W      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 1);
   localparam logic [15:0]      FRAME_LAST = 16'(PERIOD_TICKS - 1);
   localparam logic [15:0]      MIN_W      = 16'(MIN_TICKS);
   localparam logic [15:0]      MAX_W      = 16'(MAX_TICKS);

   logic [PRE_W-1:0]  pre_cnt_r;
   logic [15:0]       frame_cnt_r;
   logic [3:0][15:0]  shadow_r;
   logic [3:0][15:0]  resolved_s;
   logic [3:0]        out_r;
   logic              strobe_r;
   logic              tick_s;
   logic              wrap_s;

   // Disabled or zero commands turn the channel off; anything else is clamped.
   function automatic logic [15:0] resolve_width(input logic en, input logic [15:0] cmd);
      logic [15:0] w;
      if (!en || (cmd == 16'd0)) begin
         w = 16'd0;
      end else if (cmd < MIN_W) begin
         w = MIN_W;
      end else if (cmd > MAX_W) begin
         w = MAX_W;
      end else begin
         w = cmd;
      end
      return w;
   endfunction

   // Tick / frame-wrap decode and per-channel width resolution.
   always_comb begin
      tick_s = (pre_cnt_r == PRE_LAST);
      wrap_s = tick_s && (frame_cnt_r == FRAME_LAST);
      for (int i = 0; i < 4; i++) begin
         resolved_s[i] = resolve_width(SERVO_EN[i], SERVO_CMD[16*i +: 16]);
      end
   end

   // Prescaler and frame counter; only reset can disturb the frame cadence.
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         pre_cnt_r   <= '0;
         frame_cnt_r <= 16'd0;
      end else begin
         if (tick_s) begin
            pre_cnt_r <= '0;
            if (frame_cnt_r == FRAME_LAST) begin
               frame_cnt_r <= 16'd0;
            end else begin
               frame_cnt_r <= frame_cnt_r + 16'd1;
            end
         end else begin
            pre_cnt_r   <= pre_cnt_r + PRE_W'(1);
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   // Shadow widths reload only at frame wrap; strobe marks the new frame.
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         shadow_r <= '0;
         strobe_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            shadow_r <= resolved_s;
         end else begin
            shadow_r <= shadow_r;
         end
         strobe_r <= wrap_s;
      end
   end

   // Pulse outputs: high while the frame position is below the latched width.
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         out_r <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            out_r[i] <= (frame_cnt_r < shadow_r[i]);
         end
      end
   end

   assign SERVO_OUT     = out_r;
   assign PERIOD_STROBE = strobe_r;
   assign SERVO_STATUS  = shadow_r;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: a frame-level model predicts widths at each
// frame boundary, and a monitor checks status, pulse lengths and strobe spacing.
module tb_servo_pwm_gen;

   localparam int P     = 2;
   localparam int PT    = 100;
   localparam int MN    = 10;
   localparam int MX    = 50;
   localparam int FRAME = P * PT;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST_N;
   logic [63:0] SERVO_CMD;
   logic [3:0]  SERVO_EN;
   logic [3:0]  SERVO_OUT;
   logic        PERIOD_STROBE;
   logic [63:0] SERVO_STATUS;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   servo_pwm_gen #(.PRESCALE(P), .PERIOD_TICKS(PT), .MIN_TICKS(MN), .MAX_TICKS(MX)) dut (
      .SYS_CLK       (SYS_CLK),
      .SYS_RST_N     (SYS_RST_N),
      .SERVO_CMD     (SERVO_CMD),
      .SERVO_EN      (SERVO_EN),
      .SERVO_OUT     (SERVO_OUT),
      .PERIOD_STROBE (PERIOD_STROBE),
      .SERVO_STATUS  (SERVO_STATUS)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   function automatic logic [15:0] ref_width(input logic en, input logic [15:0] cmd);
      if (!en || cmd == 16'd0) return 16'd0;
      if (cmd < MN) return 16'(MN);
      if (cmd > MX) return 16'(MX);
      return cmd;
   endfunction

   function automatic logic [15:0] rand_cmd();
      case ($urandom_range(0, 3))
         0:       return 16'd0;
         1:       return 16'($urandom_range(1, MN - 1));
         2:       return 16'($urandom_range(MN, MX));
         default: return 16'($urandom_range(MX + 1, 65535));
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge SYS_CLK);
         #1;
      end
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin
         @(negedge SYS_CLK);
         n++;
      end while (!PERIOD_STROBE && n < FRAME + 20);
      if (!PERIOD_STROBE) begin
         checks++;
         errors++;
         $display("FAIL wait_strobe no strobe within %0d cycles", n);
      end
   endtask

   // Reference model: every FRAME clocks after release the inputs are latched.
   initial begin
      int cnt = 0;
      logic [63:0] e;
      forever begin
         @(posedge SYS_CLK);
         if (!SYS_RST_N) begin
            cnt = 0;
            exp_q.delete();
         end else begin
            cnt++;
            if (cnt % FRAME == 0) begin
               for (int c = 0; c < 4; c++) e[16*c +: 16] = ref_width(SERVO_EN[c], SERVO_CMD[16*c +: 16]);
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor: measures each frame's pulses and compares at the next strobe.
   initial begin
      int ncyc = 0, last_event = 0, offset = 0;
      int hi[4], first[4], rises[4];
      logic [3:0]  prev = 4'b0000;
      logic [63:0] cur = 64'd0;
      logic [63:0] e;
      logic [15:0] w;
      bit have_frame = 1'b0;
      for (int c = 0; c < 4; c++) begin hi[c] = 0; first[c] = -1; rises[c] = 0; end
      forever begin
         @(negedge SYS_CLK);
         ncyc++;
         if (PERIOD_STROBE) begin
            if (have_frame) begin
               for (int c = 0; c < 4; c++) begin
                  w = cur[16*c +: 16];
                  check($sformatf("pulse_ch%0d(hi,first,rises)", c),
                        {32'(hi[c]), 16'(first[c]), 16'(rises[c])},
                        (w == 16'd0) ? {32'd0, 16'hFFFF, 16'd0} : {32'(2 * w), 16'd1, 16'd1});
               end
            end
            check("strobe_spacing", 64'(ncyc - last_event), 64'(FRAME));
            last_event = ncyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe actual=strobe required=none");
               have_frame = 1'b0;
            end else begin
               e = exp_q.pop_front();
               check("status", SERVO_STATUS, e);
               cur = e;
               have_frame = 1'b1;
            end
            offset = 0;
            prev = 4'b0000;
            for (int c = 0; c < 4; c++) begin hi[c] = 0; first[c] = -1; rises[c] = 0; end
         end else if (SYS_RST_N && (ncyc - last_event > FRAME)) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing actual=none required=strobe after %0d cycles", FRAME);
            last_event = ncyc;
            have_frame = 1'b0;
         end
         for (int c = 0; c < 4; c++) begin
            if (SERVO_OUT[c]) begin
               hi[c]++;
               if (!prev[c]) rises[c]++;
               if (first[c] < 0) first[c] = offset;
            end
         end
         prev = SERVO_OUT;
         offset++;
         if (!SYS_RST_N) begin
            last_event = ncyc + 1;
            cur = 64'd0;
            have_frame = 1'b1;
            offset = -1;
            prev = 4'b0000;
            for (int c = 0; c < 4; c++) begin hi[c] = 0; first[c] = -1; rises[c] = 0; end
         end
      end
   end

   // Stimulus.
   initial begin
      int n;
      SYS_RST_N = 1'b0;
      SERVO_CMD = {16'd0, 16'd0, 16'd0, 16'd20};
      SERVO_EN  = 4'b0001;
      step(3);
      check("reset_out_strobe", {59'd0, SERVO_OUT, PERIOD_STROBE}, 64'd0);
      check("reset_status", SERVO_STATUS, 64'd0);
      SYS_RST_N = 1'b1;

      wait_strobe();
      step(20);
      SERVO_CMD[31:16] = 16'd3;
      SERVO_CMD[47:32] = 16'd900;
      SERVO_CMD[63:48] = 16'd0;
      SERVO_EN = 4'hF;

      wait_strobe();
      wait_strobe();
      step(10);
      SERVO_CMD[15:0] = 16'd35;

      wait_strobe();
      step(30);
      SERVO_EN[0] = 1'b0;

      wait_strobe();
      step(5);
      SERVO_EN[0] = 1'b1;

      wait_strobe();
      n = 0;
      while (!SERVO_OUT[0] && n < FRAME + 20) begin
         @(negedge SYS_CLK);
         n++;
      end
      if (!SERVO_OUT[0]) begin
         checks++;
         errors++;
         $display("FAIL wait_out0 actual=0 required=1");
      end
      @(posedge SYS_CLK);
      #1;
      SYS_RST_N = 1'b0;
      step(1);
      check("midpulse_reset_out_strobe", {59'd0, SERVO_OUT, PERIOD_STROBE}, 64'd0);
      check("midpulse_reset_status", SERVO_STATUS, 64'd0);
      SYS_RST_N = 1'b1;

      wait_strobe();
      for (int f = 0; f < 10; f++) begin
         wait_strobe();
         step($urandom_range(1, FRAME - 60));
         for (int c = 0; c < 4; c++) begin
            SERVO_CMD[16*c +: 16] = rand_cmd();
            SERVO_EN[c] = ($urandom_range(0, 3) != 0);
         end
      end
      wait_strobe();
      wait_strobe();
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
